// File: rtl/rect_pkg.sv
// Shared types and defaults for the rectangle fill engine.
// The command layout packed into the queue is {x, y, w, h, colour}, MSB first.
package rect_pkg;

    localparam int unsigned X_W_DEF      = 8;
    localparam int unsigned Y_W_DEF      = 7;
    localparam int unsigned COLOUR_W_DEF = 3;
    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun
    } rect_state_e;

    // Reference layout of one queued command at the default widths.
    typedef struct packed {
        logic [X_W_DEF-1:0]      x;
        logic [Y_W_DEF-1:0]      y;
        logic [X_W_DEF-1:0]      w;
        logic [Y_W_DEF-1:0]      h;
        logic [COLOUR_W_DEF-1:0] colour;
    } rect_cmd_t;

    function automatic int unsigned cmd_width(int unsigned xw, int unsigned yw,
                                              int unsigned cw);
        return xw + yw + xw + yw + cw;
    endfunction

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module rect_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle rasteriser: queues draw commands and emits one pixel per cycle
// in row-major order towards the VGA adapter.
// Optional build macro RECT_CLIP_EN suppresses the plot strobe for pixels
// outside the visible screen; otherwise coordinates wrap at the field width.
module rect_fill_engine
    import rect_pkg::*;
#(
    parameter int unsigned X_W        = X_W_DEF,
    parameter int unsigned Y_W        = Y_W_DEF,
    parameter int unsigned COLOUR_W   = COLOUR_W_DEF,
    parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [X_W-1:0]      req_x,
    input  logic [Y_W-1:0]      req_y,
    input  logic [X_W-1:0]      req_w,
    input  logic [Y_W-1:0]      req_h,
    input  logic [COLOUR_W-1:0] req_colour,
    output logic [X_W-1:0]      out_x,
    output logic [Y_W-1:0]      out_y,
    output logic [COLOUR_W-1:0] out_colour,
    output logic                out_plot,
    output logic                done,
    output logic                busy
);

    localparam int unsigned CMD_W = cmd_width(X_W, Y_W, COLOUR_W);

    // Elaboration-time sanity checks on the configuration.
    if (SCREEN_W > (2 ** X_W) || SCREEN_H > (2 ** Y_W)) begin : g_bad_screen
        $error("screen size exceeds coordinate width");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    rect_state_e         state_q, state_d;
    logic [X_W-1:0]      x_q, x_d, w_q, w_d, cx_q, cx_d;
    logic [Y_W-1:0]      y_q, y_d, h_q, h_d, cy_q, cy_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [X_W-1:0]      out_x_q, out_x_d;
    logic [Y_W-1:0]      out_y_q, out_y_d;
    logic [COLOUR_W-1:0] out_colour_q, out_colour_d;
    logic                plot_q, plot_d;
    logic                done_q, done_d;

    logic [CMD_W-1:0]    push_data, pop_data;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [X_W-1:0]      pop_x, pop_w;
    logic [Y_W-1:0]      pop_y, pop_h;
    logic [COLOUR_W-1:0] pop_colour;

    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;
    logic                pix_plot;

    // Ready comes from the registered count only: no bypass when full.
    assign req_ready = !fifo_full && !reset;
    assign fifo_push = req_valid && req_ready;
    assign push_data = {req_x, req_y, req_w, req_h, req_colour};
    assign {pop_x, pop_y, pop_w, pop_h, pop_colour} = pop_data;

    rect_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (push_data),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef RECT_CLIP_EN
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;
    assign sum_x    = {1'b0, x_q} + {1'b0, cx_q};
    assign sum_y    = {1'b0, y_q} + {1'b0, cy_q};
    assign pix_x    = sum_x[X_W-1:0];
    assign pix_y    = sum_y[Y_W-1:0];
    assign pix_plot = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
`else
    // Carry-out is dropped: off-screen coordinates wrap around.
    assign pix_x    = x_q + cx_q;
    assign pix_y    = y_q + cy_q;
    assign pix_plot = 1'b1;
`endif

    // Next-state, command capture and pixel generation.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        w_d          = w_q;
        h_d          = h_q;
        colour_d     = colour_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_colour_d = out_colour_q;
        plot_d       = 1'b0;
        done_d       = 1'b0;
        fifo_pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    x_d      = pop_x;
                    y_d      = pop_y;
                    w_d      = pop_w;
                    h_d      = pop_h;
                    colour_d = pop_colour;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (w_q == '0 || h_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                out_x_d      = pix_x;
                out_y_d      = pix_y;
                out_colour_d = colour_q;
                plot_d       = pix_plot;
                if (cx_q == w_q - X_W'(1)) begin
                    cx_d = '0;
                    cy_d = cy_q + Y_W'(1);
                    if (cy_q == h_q - Y_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset discards any in-flight rectangle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            colour_q     <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_colour_q <= '0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            w_q          <= w_d;
            h_q          <= h_d;
            colour_q     <= colour_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_colour_q <= out_colour_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
        end
    end

    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_colour_q;
    assign out_plot   = plot_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine. A reference model expands every
// accepted command into the expected pixel/done stream; a monitor checks it.
module tb_rect_fill_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_x = '0;
    logic [6:0] req_y = '0;
    logic [7:0] req_w = '0;
    logic [6:0] req_h = '0;
    logic [2:0] req_colour = '0;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_plot;
    logic       done;
    logic       busy;

    always #5 clock = ~clock;

    rect_fill_engine dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .out_plot   (out_plot),
        .done       (done),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int plot_count = 0;

    // plot=1: a visible pixel (last marks the done pulse); plot=0: done alone.
    typedef struct {
        int x;
        int y;
        int col;
        bit plot;
        bit last;
    } ev_t;
    ev_t exp_q[$];

    function automatic void model_push(int x, int y, int w, int h, int col);
        ev_t e;
        bit  vis;
        if (w == 0 || h == 0) begin
            e = '{x: 0, y: 0, col: col, plot: 1'b0, last: 1'b1};
            exp_q.push_back(e);
            return;
        end
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
`ifdef RECT_CLIP_EN
                vis = (x + c < 160) && (y + r < 120);
`else
                vis = 1'b1;
`endif
                e = '{x: (x + c) % 256, y: (y + r) % 128, col: col, plot: 1'b1,
                      last: (c == w - 1) && (r == h - 1)};
                if (vis) exp_q.push_back(e);
                else if (e.last) begin
                    e.plot = 1'b0;
                    exp_q.push_back(e);
                end
            end
        end
    endfunction

    // Stream monitor against the reference model.
    always @(negedge clock) begin
        ev_t e;
        if (!reset && (out_plot || done)) begin
            n_vec++;
            if (out_plot) plot_count++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL stream: unexpected plot=%0b done=%0b at (%0d,%0d), required nothing",
                         out_plot, done, out_x, out_y);
            end else begin
                e = exp_q.pop_front();
                if (out_plot !== e.plot || done !== e.last ||
                    (e.plot && (out_x !== 8'(e.x) || out_y !== 7'(e.y) ||
                                out_colour !== 3'(e.col)))) begin
                    n_err++;
                    $display("FAIL stream: got plot=%0b done=%0b (%0d,%0d) c%0d, required plot=%0b done=%0b (%0d,%0d) c%0d",
                             out_plot, done, out_x, out_y, out_colour,
                             e.plot, e.last, e.x, e.y, e.col);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int x, input int y, input int w, input int h, input int col);
        bit ok = 1'b0;
        req_x = 8'(x); req_y = 7'(y); req_w = 8'(w); req_h = 7'(h); req_colour = 3'(col);
        req_valid = 1'b1;
        for (int i = 0; i < 40000 && !ok; i++) begin
            if (req_ready) begin
                model_push(x, y, w, h, col);
                ok = 1'b1;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL send: accepted=0, required 1");
        end
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy !== 1'b0 && i < budget) begin
            @(negedge clock);
            i++;
        end
        repeat (2) @(negedge clock);
        n_vec++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL idle: busy=%0b pending=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_vec++;
        if ({out_plot, done, busy, req_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: plot/done/busy/ready=%b, required 0000",
                     {out_plot, done, busy, req_ready});
        end
        n_vec++;
        if ({out_x, out_y, out_colour} !== 18'd0) begin
            n_err++;
            $display("FAIL reset_data: x=%0d y=%0d c=%0d, required 0 0 0", out_x, out_y, out_colour);
        end
        reset = 1'b0;
        @(negedge clock);
        n_vec++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ready=%0b busy=%0b, required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        int px[$];
        int py[$];
        int first = -1, lastp = -1, ndone = 0, done_at = -1;
        send(76, 110, 16, 2, 7);
        for (int i = 0; i < 200 && done_at < 0; i++) begin
            if (out_plot) begin
                px.push_back(int'(out_x));
                py.push_back(int'(out_y));
                if (first < 0) first = i;
                lastp = i;
            end
            if (done) begin
                ndone++;
                done_at = i;
            end
            @(negedge clock);
        end
        n_vec++;
        if (px.size() != 32 || lastp - first + 1 != 32) begin
            n_err++;
            $display("FAIL single_count: plots=%0d span=%0d, required 32 32", px.size(), lastp - first + 1);
        end else begin
            n_vec++;
            if (px[0] != 76 || py[0] != 110 || px[15] != 91 || py[15] != 110 ||
                px[16] != 76 || py[16] != 111 || px[31] != 91 || py[31] != 111) begin
                n_err++;
                $display("FAIL single_corners: (%0d,%0d) (%0d,%0d) (%0d,%0d) (%0d,%0d), required (76,110) (91,110) (76,111) (91,111)",
                         px[0], py[0], px[15], py[15], px[16], py[16], px[31], py[31]);
            end
        end
        n_vec++;
        if (ndone != 1 || done_at != lastp) begin
            n_err++;
            $display("FAIL single_done: pulses=%0d at=%0d, required 1 at %0d", ndone, done_at, lastp);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_busy: busy=%0b, required 0", busy);
        end
        wait_idle(50);
    endtask

    task automatic test_zero_size();
        int nplot = 0;
        int dt[$];
        send(10, 20, 0, 5, 3);
        send(10, 20, 5, 0, 4);
        for (int i = 0; i < 30; i++) begin
            if (out_plot) nplot++;
            if (done) dt.push_back(i);
            @(negedge clock);
        end
        n_vec++;
        if (nplot != 0 || dt.size() != 2) begin
            n_err++;
            $display("FAIL zero_size: plots=%0d dones=%0d, required 0 2", nplot, dt.size());
        end else begin
            n_vec++;
            if (dt[1] - dt[0] != 2) begin
                n_err++;
                $display("FAIL zero_spacing: %0d cycles, required 2", dt[1] - dt[0]);
            end
        end
        wait_idle(50);
    endtask

    task automatic test_backpressure();
        int acc = 0, ready_seen = 0, gap = 0, i = 0;
        bit got;
        send(0, 0, 160, 120, 1);
        while (!out_plot && i < 20) begin
            @(negedge clock);
            i++;
        end
        for (int k = 0; k < 6; k++) begin
            int x = $urandom_range(100), y = $urandom_range(100);
            int w = $urandom_range(8, 1), h = $urandom_range(4, 1), c = $urandom_range(7);
            req_x = 8'(x); req_y = 7'(y); req_w = 8'(w); req_h = 7'(h); req_colour = 3'(c);
            req_valid = 1'b1;
            got = 1'b0;
            for (int j = 0; j < 5 && !got; j++) begin
                if (req_ready) begin
                    model_push(x, y, w, h, c);
                    acc++;
                    got = 1'b1;
                end
                @(negedge clock);
            end
        end
        req_valid = 1'b0;
        n_vec++;
        if (acc != 4 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: accepted=%0d ready=%0b, required 4 0", acc, req_ready);
        end
        i = 0;
        while (done !== 1'b1 && i < 20000) begin
            if (req_ready) ready_seen++;
            @(negedge clock);
            i++;
        end
        n_vec++;
        if (done !== 1'b1 || ready_seen != 0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold: done=%0b ready_cycles=%0d ready=%0b, required 1 0 0",
                     done, ready_seen, req_ready);
        end
        @(negedge clock);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: ready=%0b, required 1", req_ready);
        end
        while (!out_plot && gap < 10) begin
            gap++;
            @(negedge clock);
        end
        n_vec++;
        if (gap != 2) begin
            n_err++;
            $display("FAIL bp_gap: %0d idle cycles, required 2", gap);
        end
        wait_idle(2000);
    endtask

    task automatic test_clip();
        int nplot = 0, first = -1, done_at = -1, nbad = 0;
        int xs[$];
        send(155, 118, 10, 4, 5);
        for (int i = 0; i < 100 && done_at < 0; i++) begin
            if (out_plot) begin
                nplot++;
                if (first < 0) first = i;
            end
            if (done) done_at = i;
            @(negedge clock);
        end
        n_vec++;
`ifdef RECT_CLIP_EN
        if (nplot != 10 || done_at - first + 1 != 40) begin
            n_err++;
            $display("FAIL clip_count: plots=%0d done_cycle=%0d, required 10 40", nplot, done_at - first + 1);
        end
`else
        if (nplot != 40 || done_at - first + 1 != 40) begin
            n_err++;
            $display("FAIL clip_count: plots=%0d done_cycle=%0d, required 40 40", nplot, done_at - first + 1);
        end
`endif
        wait_idle(50);
        send(250, 5, 10, 1, 2);
        for (int i = 0; i < 40; i++) begin
            if (out_plot) xs.push_back(int'(out_x));
            @(negedge clock);
        end
        n_vec++;
`ifdef RECT_CLIP_EN
        if (xs.size() != 0) begin
            n_err++;
            $display("FAIL wrap_clip: plots=%0d, required 0", xs.size());
        end
`else
        if (xs.size() != 10) begin
            n_err++;
            $display("FAIL wrap_count: plots=%0d, required 10", xs.size());
        end else begin
            foreach (xs[k]) if (xs[k] != (250 + k) % 256) nbad++;
            if (nbad != 0) begin
                n_err++;
                $display("FAIL wrap_x: %0d wrong columns (first %0d last %0d), required 250..255,0..3",
                         nbad, xs[0], xs[9]);
            end
        end
`endif
        wait_idle(50);
    endtask

    task automatic test_reset_mid();
        int base = plot_count, i = 0, after = 0;
        send(20, 30, 16, 2, 6);
        send(30, 40, 4, 4, 1);
        send(50, 60, 3, 3, 2);
        while (plot_count - base < 10 && i < 100) begin
            @(negedge clock);
            #1;
            i++;
        end
        reset = 1'b1;
        @(negedge clock);
        n_vec++;
        if ({out_plot, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid: plot/busy/done=%b after %0d plots, required 000",
                     {out_plot, busy, done}, plot_count - base);
        end
        exp_q.delete();
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (out_plot || done) after++;
            @(negedge clock);
        end
        n_vec++;
        if (after != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_discard: activity=%0d busy=%0b, required 0 0", after, busy);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            send($urandom_range(255), $urandom_range(127), $urandom_range(20),
                 $urandom_range(6), $urandom_range(7));
        end
        wait_idle(5000);
    endtask

    task automatic test_full_clear();
        int cnt = 0, holes = 0, i = 0;
        bit started = 1'b0;
        send(0, 0, 160, 120, 0);
        while (done !== 1'b1 && i < 19400) begin
            if (out_plot) begin
                cnt++;
                started = 1'b1;
            end else if (started) holes++;
            @(negedge clock);
            i++;
        end
        if (out_plot) cnt++;
        n_vec++;
        if (done !== 1'b1 || out_plot !== 1'b1 || out_x !== 8'd159 || out_y !== 7'd119) begin
            n_err++;
            $display("FAIL clear_last: done=%0b plot=%0b (%0d,%0d), required 1 1 (159,119)",
                     done, out_plot, out_x, out_y);
        end
        n_vec++;
        if (cnt != 19200 || holes != 0) begin
            n_err++;
            $display("FAIL clear_count: plots=%0d gaps=%0d, required 19200 0", cnt, holes);
        end
        wait_idle(50);
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single();
        test_zero_size();
        test_backpressure();
        test_clip();
        test_reset_mid();
        test_random();
        test_full_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
